// File: rtl/rs232_command_parser_pkg.sv
// Shared types and constants for the framed RS-232 command parser.
// Holds the frame FSM states, the error codes and the default framing characters.
package rs232_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    H1,
    OP,
    ARG,
    TERM
  } state_t;

  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TERM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] CHAR_HDR0 = 8'h63;
  localparam logic [7:0] CHAR_HDR1 = 8'h6D;
  localparam logic [7:0] CHAR_OP_G = 8'h67;
  localparam logic [7:0] CHAR_OP_D = 8'h64;
  localparam logic [7:0] CHAR_TERM = 8'h0D;

  // cmd_arg keeps at least one byte of width so the port never collapses to zero bits
  function automatic int arg_width(input int arg_bytes);
    return ((arg_bytes > 0) ? arg_bytes : 1) * 8;
  endfunction

endpackage

// File: rtl/rs232_command_parser_if.sv
// Byte-in / command-out bundle between a UART receiver and the command parser.
// The master side feeds received bytes; the slave side is the parser.
interface rs232_command_parser_if #(
  parameter int ARG_W = 16
);

  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             cmd_valid;
  logic [3:0]       cmd_code;
  logic [ARG_W-1:0] cmd_arg;
  logic             cmd_error;
  logic [1:0]       err_code;

  modport master (
    output rx_byte,
    output rx_valid,
    input  cmd_valid,
    input  cmd_code,
    input  cmd_arg,
    input  cmd_error,
    input  err_code
  );

  modport slave (
    input  rx_byte,
    input  rx_valid,
    output cmd_valid,
    output cmd_code,
    output cmd_arg,
    output cmd_error,
    output err_code
  );

endinterface

// File: rtl/rs232_command_parser_byte_strobe.sv
// Turns the UART's rx_valid level into a single-cycle accept pulse on each rising edge.
// Shared by every consumer sitting behind the UART receiver.
module rs232_byte_strobe (
  input  logic clock,
  input  logic reset,
  input  logic i_valid,
  output logic o_accept
);

  logic r_valid_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid_last <= 1'b0;
    end else begin
      r_valid_last <= i_valid;
    end
  end

  assign o_accept = i_valid & ~r_valid_last;

endmodule

// File: rtl/rs232_command_parser.sv
// Framed command parser: header, table-decoded opcode, raw argument bytes, optional terminator.
// Emits one-cycle command/error strobes and aborts stalled frames after an inter-byte timeout.
module rs232_command_parser
  import rs232_cmd_pkg::*;
#(
  parameter logic [7:0]            HDR0           = CHAR_HDR0,
  parameter logic [7:0]            HDR1           = CHAR_HDR1,
  parameter int                    NUM_CMDS       = 2,
  parameter logic [NUM_CMDS*8-1:0] OPCODES        = {CHAR_OP_G, CHAR_OP_D},
  parameter int                    ARG_BYTES      = 2,
  parameter bit                    USE_TERM       = 1'b1,
  parameter logic [7:0]            TERM_CHAR      = CHAR_TERM,
  parameter int unsigned           TIMEOUT_CYCLES = 1000000
) (
  input logic                   clock,
  input logic                   reset,
  rs232_command_parser_if.slave bus
);

  localparam int ARG_W = arg_width(ARG_BYTES);

  logic w_accept;

  rs232_byte_strobe u_byte_strobe (
    .clock    (clock),
    .reset    (reset),
    .i_valid  (bus.rx_valid),
    .o_accept (w_accept)
  );

  state_t           r_state,     w_state_n;
  logic [31:0]      r_count,     w_count_n;
  logic [ARG_W-1:0] r_arg,       w_arg_n;
  logic [2:0]       r_arg_cnt,   w_arg_cnt_n;
  logic [3:0]       r_pend_code, w_pend_code_n;
  logic             r_cmd_valid, w_cmd_valid_n;
  logic [3:0]       r_cmd_code,  w_cmd_code_n;
  logic [ARG_W-1:0] r_cmd_arg,   w_cmd_arg_n;
  logic             r_cmd_error, w_cmd_error_n;
  logic [1:0]       r_err_code,  w_err_code_n;

  logic             w_expire;
  logic             w_op_hit;
  logic [3:0]       w_op_code;
  logic [ARG_W-1:0] w_arg_shift;
  logic [2:0]       w_arg_cnt_inc;

  // Descending scan so the lowest matching table index is the one left standing
  always_comb begin
    w_op_hit  = 1'b0;
    w_op_code = 4'd0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (OPCODES[8*i +: 8] == bus.rx_byte) begin
        w_op_hit  = 1'b1;
        w_op_code = 4'(i + 1);
      end
    end
  end

  always_comb begin
    w_expire = 1'b0;
    if ((TIMEOUT_CYCLES != 0) && (r_state != IDLE)) begin
      w_expire = (r_count + 32'd1) >= (TIMEOUT_CYCLES - 32'd1);
    end
  end

  assign w_arg_shift   = (r_arg << 8) | ARG_W'(bus.rx_byte);
  assign w_arg_cnt_inc = r_arg_cnt + 3'd1;

  // An accepted byte always takes priority over a timeout expiring on the same clock
  always_comb begin
    w_state_n     = r_state;
    w_count_n     = (w_accept || (r_state == IDLE)) ? 32'd0 : r_count + 32'd1;
    w_arg_n       = r_arg;
    w_arg_cnt_n   = r_arg_cnt;
    w_pend_code_n = r_pend_code;
    w_cmd_valid_n = 1'b0;
    w_cmd_code_n  = r_cmd_code;
    w_cmd_arg_n   = r_cmd_arg;
    w_cmd_error_n = 1'b0;
    w_err_code_n  = r_err_code;

    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (bus.rx_byte == HDR0) w_state_n = H1;
        end
        H1: begin
          if (bus.rx_byte == HDR1)      w_state_n = OP;
          else if (bus.rx_byte == HDR0) w_state_n = H1;
          else                          w_state_n = IDLE;
        end
        OP: begin
          if (w_op_hit) begin
            w_pend_code_n = w_op_code;
            w_arg_n       = '0;
            w_arg_cnt_n   = 3'd0;
            if (ARG_BYTES > 0) begin
              w_state_n = ARG;
            end else if (USE_TERM) begin
              w_state_n = TERM;
            end else begin
              w_cmd_valid_n = 1'b1;
              w_cmd_code_n  = w_op_code;
              w_cmd_arg_n   = '0;
              w_state_n     = IDLE;
            end
          end else begin
            w_cmd_error_n = 1'b1;
            w_err_code_n  = ERR_OPCODE;
            w_state_n     = IDLE;
          end
        end
        ARG: begin
          w_arg_n     = w_arg_shift;
          w_arg_cnt_n = w_arg_cnt_inc;
          if (w_arg_cnt_inc == 3'(ARG_BYTES)) begin
            if (USE_TERM) begin
              w_state_n = TERM;
            end else begin
              w_cmd_valid_n = 1'b1;
              w_cmd_code_n  = r_pend_code;
              w_cmd_arg_n   = w_arg_shift;
              w_state_n     = IDLE;
            end
          end
        end
        TERM: begin
          if (bus.rx_byte == TERM_CHAR) begin
            w_cmd_valid_n = 1'b1;
            w_cmd_code_n  = r_pend_code;
            w_cmd_arg_n   = (ARG_BYTES > 0) ? r_arg : '0;
          end else begin
            w_cmd_error_n = 1'b1;
            w_err_code_n  = ERR_TERM;
          end
          w_state_n = IDLE;
        end
        default: w_state_n = IDLE;
      endcase
    end else if (w_expire) begin
      w_cmd_error_n = 1'b1;
      w_err_code_n  = ERR_TIMEOUT;
      w_state_n     = IDLE;
      w_count_n     = 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= 32'd0;
      r_arg       <= '0;
      r_arg_cnt   <= 3'd0;
      r_pend_code <= 4'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 4'd0;
      r_cmd_arg   <= '0;
      r_cmd_error <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_state     <= w_state_n;
      r_count     <= w_count_n;
      r_arg       <= w_arg_n;
      r_arg_cnt   <= w_arg_cnt_n;
      r_pend_code <= w_pend_code_n;
      r_cmd_valid <= w_cmd_valid_n;
      r_cmd_code  <= w_cmd_code_n;
      r_cmd_arg   <= w_cmd_arg_n;
      r_cmd_error <= w_cmd_error_n;
      r_err_code  <= w_err_code_n;
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_code  = r_cmd_code;
  assign bus.cmd_arg   = r_cmd_arg;
  assign bus.cmd_error = r_cmd_error;
  assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_rs232_command_parser.sv
// Directed bench for the command parser: good frames, resync, opcode/terminator/timeout errors, reset.
// The DUT runs with a 50-cycle timeout so timeout behaviour is reachable quickly.
module tb_rs232_command_parser;

  logic clock = 1'b0;
  logic reset;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycleCount    = 0;
  int validCount    = 0;
  int errorCount    = 0;
  int errCycle      = 0;
  int acceptCycle   = 0;
  int v0;
  int e0;

  logic [7:0] frame[$];

  rs232_command_parser_if #(.ARG_W(16)) bus ();

  rs232_command_parser #(
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Strobes are sampled mid-cycle so every high cycle is counted exactly once
  always @(negedge clock) begin
    if (bus.cmd_valid) validCount <= validCount + 1;
    if (bus.cmd_error) begin
      errorCount <= errorCount + 1;
      errCycle   <= cycleCount;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clock);
    acceptCycle  = cycleCount;
    bus.rx_valid = 1'b0;
    @(posedge clock);
  endtask

  task automatic applyFrame();
    foreach (frame[i]) applyStimulus(frame[i]);
  endtask

  task automatic settle();
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic snapshot();
    v0 = validCount;
    e0 = errorCount;
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_valid", 32'(bus.cmd_valid), 32'd0);
    checkOutput("rst_code",  32'(bus.cmd_code),  32'd0);
    checkOutput("rst_arg",   32'(bus.cmd_arg),   32'd0);
    checkOutput("rst_error", 32'(bus.cmd_error), 32'd0);
    checkOutput("rst_ecode", 32'(bus.err_code),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    settle();

    $display("[TB] basic cmd frame");
    snapshot();
    frame = '{8'h63, 8'h6D, 8'h64, 8'h12, 8'h34, 8'h0D};
    applyFrame();
    settle();
    checkOutput("t1_valid_cnt", 32'(validCount - v0), 32'd1);
    checkOutput("t1_code",      32'(bus.cmd_code),    32'd1);
    checkOutput("t1_arg",       32'(bus.cmd_arg),     32'h1234);
    checkOutput("t1_err_cnt",   32'(errorCount - e0), 32'd0);

    $display("[TB] resync on duplicate header");
    snapshot();
    frame = '{8'h63, 8'h63, 8'h6D, 8'h67, 8'hAB, 8'hCD, 8'h0D};
    applyFrame();
    settle();
    checkOutput("t2_valid_cnt", 32'(validCount - v0), 32'd1);
    checkOutput("t2_code",      32'(bus.cmd_code),    32'd2);
    checkOutput("t2_arg",       32'(bus.cmd_arg),     32'hABCD);

    $display("[TB] unknown opcode then recovery");
    snapshot();
    frame = '{8'h63, 8'h6D, 8'h78};
    applyFrame();
    settle();
    checkOutput("t3_err_cnt",   32'(errorCount - e0), 32'd1);
    checkOutput("t3_ecode",     32'(bus.err_code),    32'd1);
    checkOutput("t3_valid_cnt", 32'(validCount - v0), 32'd0);
    snapshot();
    frame = '{8'h63, 8'h6D, 8'h64, 8'h11, 8'h22, 8'h0D};
    applyFrame();
    settle();
    checkOutput("t3b_valid_cnt", 32'(validCount - v0), 32'd1);
    checkOutput("t3b_code",      32'(bus.cmd_code),    32'd1);
    checkOutput("t3b_arg",       32'(bus.cmd_arg),     32'h1122);

    $display("[TB] bad terminator");
    snapshot();
    frame = '{8'h63, 8'h6D, 8'h67, 8'h01, 8'h02, 8'h0A};
    applyFrame();
    settle();
    checkOutput("t4_err_cnt",   32'(errorCount - e0), 32'd1);
    checkOutput("t4_ecode",     32'(bus.err_code),    32'd2);
    checkOutput("t4_valid_cnt", 32'(validCount - v0), 32'd0);
    checkOutput("t4_code_held", 32'(bus.cmd_code),    32'd1);
    checkOutput("t4_arg_held",  32'(bus.cmd_arg),     32'h1122);

    $display("[TB] rx_valid held high delivers one byte");
    snapshot();
    @(negedge clock);
    bus.rx_byte  = 8'h63;
    bus.rx_valid = 1'b1;
    repeat (60) @(negedge clock);
    bus.rx_valid = 1'b0;
    settle();
    checkOutput("held_err_cnt", 32'(errorCount - e0), 32'd1);
    checkOutput("held_ecode",   32'(bus.err_code),    32'd3);

    $display("[TB] timeout latency");
    snapshot();
    frame = '{8'h63, 8'h6D};
    applyFrame();
    repeat (60) @(posedge clock);
    #1;
    checkOutput("to_err_cnt",   32'(errorCount - e0),       32'd1);
    checkOutput("to_ecode",     32'(bus.err_code),          32'd3);
    checkOutput("to_latency",   32'(errCycle - acceptCycle), 32'd49);
    checkOutput("to_valid_cnt", 32'(validCount - v0),       32'd0);

    $display("[TB] byte on expiry clock wins");
    snapshot();
    frame = '{8'h63, 8'h6D};
    applyFrame();
    repeat (47) @(posedge clock);
    applyStimulus(8'h64);
    frame = '{8'h55, 8'h66, 8'h0D};
    applyFrame();
    settle();
    checkOutput("race_err_cnt",   32'(errorCount - e0), 32'd0);
    checkOutput("race_valid_cnt", 32'(validCount - v0), 32'd1);
    checkOutput("race_code",      32'(bus.cmd_code),    32'd1);
    checkOutput("race_arg",       32'(bus.cmd_arg),     32'h5566);

    $display("[TB] reset mid-frame");
    snapshot();
    @(negedge clock);
    bus.rx_byte  = 8'h63;
    bus.rx_valid = 1'b1;
    repeat (20) @(negedge clock);
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("mrst_valid",     32'(bus.cmd_valid),   32'd0);
    checkOutput("mrst_code",      32'(bus.cmd_code),    32'd0);
    checkOutput("mrst_arg",       32'(bus.cmd_arg),     32'd0);
    checkOutput("mrst_error",     32'(bus.cmd_error),   32'd0);
    checkOutput("mrst_ecode",     32'(bus.err_code),    32'd0);
    checkOutput("mrst_err_cnt",   32'(errorCount - e0), 32'd0);
    checkOutput("mrst_valid_cnt", 32'(validCount - v0), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    settle();
    snapshot();
    frame = '{8'h63, 8'h6D, 8'h64, 8'h00, 8'h00, 8'h0D};
    applyFrame();
    settle();
    checkOutput("post_valid_cnt", 32'(validCount - v0), 32'd1);
    checkOutput("post_code",      32'(bus.cmd_code),    32'd1);
    checkOutput("post_arg",       32'(bus.cmd_arg),     32'h0000);
    checkOutput("post_err_cnt",   32'(errorCount - e0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
